// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a sign fixup on the final iteration.
module muldiv_unit #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned TagWidth  = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [2:0]           op_i,
    input  logic [DataWidth-1:0] src1_i,
    input  logic [DataWidth-1:0] src2_i,
    input  logic [TagWidth-1:0]  tag_i,
    input  logic                 flush_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] result_o,
    output logic [TagWidth-1:0]  tag_o,
    output logic                 busy_o
);

    localparam int unsigned CntWidth = $clog2(DataWidth);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [2:0]             op_q, op_d;
    logic [TagWidth-1:0]    tag_q, tag_d;
    logic                   neg_q, neg_d;
    // hi: product high half / partial remainder; lo: multiplier / dividend -> quotient;
    // opnd: multiplicand / divisor.
    logic [DataWidth-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [DataWidth-1:0]   result_q, result_d;

    logic                   s1_neg, s2_neg, is_div, div_zero, div_ovf;
    logic [DataWidth-1:0]   mag1, mag2, special_res;
    logic [DataWidth:0]     mul_sum, div_shift, div_diff;
    logic [DataWidth-1:0]   step_hi, step_lo, quo_fix, rem_fix, final_res;
    logic [2*DataWidth-1:0] prod, prod_fix;

    // Operand decode at accept time: signedness, magnitudes and special cases.
    always_comb begin
        s1_neg   = (op_i != 3'b011) && (op_i != 3'b101) && (op_i != 3'b111)
                   && src1_i[DataWidth-1];
        s2_neg   = ((op_i == 3'b000) || (op_i == 3'b001) || (op_i == 3'b100)
                   || (op_i == 3'b110)) && src2_i[DataWidth-1];
        mag1     = s1_neg ? (~src1_i + 1'b1) : src1_i;
        mag2     = s2_neg ? (~src2_i + 1'b1) : src2_i;
        is_div   = op_i[2];
        div_zero = is_div && (src2_i == '0);
        // Only DIV (100) and REM (110) are signed divides.
        div_ovf  = is_div && !op_i[0] && (src1_i == {1'b1, {(DataWidth-1){1'b0}}})
                   && (src2_i == '1);
        if (div_zero) begin
            special_res = op_i[1] ? src1_i : '1;
        end else begin
            special_res = op_i[1] ? '0 : src1_i;
        end
    end

    // One iteration of the datapath plus the sign-corrected final result.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[DataWidth-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            // The partial remainder stays below the divisor, so bit DataWidth is the borrow.
            if (!div_diff[DataWidth]) begin
                step_hi = div_diff[DataWidth-1:0];
                step_lo = {lo_q[DataWidth-2:0], 1'b1};
            end else begin
                step_hi = div_shift[DataWidth-1:0];
                step_lo = {lo_q[DataWidth-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[DataWidth:1];
            step_lo = {mul_sum[0], lo_q[DataWidth-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? (~prod + 1'b1) : prod;
        quo_fix  = neg_q ? (~step_lo + 1'b1) : step_lo;
        rem_fix  = neg_q ? (~step_hi + 1'b1) : step_hi;
        if (op_q[2]) begin
            final_res = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q[1:0] == 2'b00) begin
            final_res = prod_fix[DataWidth-1:0];
        end else begin
            final_res = prod_fix[2*DataWidth-1:DataWidth];
        end
    end

    // Next-state logic for the control FSM and datapath registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        tag_d    = tag_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (valid_i && !flush_i) begin
                    op_d   = op_i;
                    tag_d  = tag_i;
                    // REM/REMU take the dividend's sign; everything else the sign product.
                    neg_d  = (is_div && op_i[1]) ? s1_neg : (s1_neg ^ s2_neg);
                    hi_d   = '0;
                    lo_d   = is_div ? mag1 : mag2;
                    opnd_d = is_div ? mag2 : mag1;
                    cnt_d  = CntWidth'(DataWidth - 1);
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = StDone;
                    end else begin
                        state_d  = StCalc;
                    end
                end
            end
            StCalc: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        result_d = final_res;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                if (flush_i || ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            tag_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

    // Outputs: only ready_o looks at an input (flush_i).
    always_comb begin
        ready_o  = (state_q == StIdle) && !flush_i;
        valid_o  = (state_q == StDone);
        busy_o   = (state_q != StIdle);
        result_o = result_q;
        tag_o    = tag_q;
    end

endmodule
